// File: rtl/gr_cntr_if.sv
// gr_cntr_if: carries the Gray-coded count from gr_cntr to its consumers.
//   WIDTH - count width in bits
//   gr    - Gray-coded count (driven by master, observed by slave)
interface gr_cntr_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] gr;

    modport master (output gr);
    modport slave  (input  gr);
endinterface

// File: rtl/gr_cntr.sv
// gr_cntr: free-running up-counter with a registered Gray-coded output.
// Exactly one output bit changes per clock, including across wrap-around,
// so the count is safe to synchronise into another clock domain.
//
// Ports:
//   clk   - rising-edge clock, single domain
//   rst   - synchronous active-high reset
//   gr_if - master modport; gr_if.gr is the Gray count, straight from a flop
module gr_cntr #(
    parameter int unsigned WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    gr_cntr_if.master gr_if
);

    // Both flops power up at zero so the output is defined before any reset.
    logic [WIDTH-1:0] bin_q = '0;
    logic [WIDTH-1:0] gr_q  = '0;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gr_d;

    always_comb begin
        bin_d = bin_q + 1'b1;
        // Gray is derived from the next binary value so it updates on the
        // same edge as the binary count, with no extra pipeline stage.
        gr_d  = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q <= '0;
            gr_q  <= '0;
        end else begin
            bin_q <= bin_d;
            gr_q  <= gr_d;
        end
    end

    assign gr_if.gr = gr_q;

endmodule

// File: tb/tb_gr_cntr.sv
// tb_gr_cntr: directed self-checking bench for gr_cntr at WIDTH=4 and WIDTH=6.
module tb_gr_cntr;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    gr_cntr_if #(.WIDTH(4)) if4 ();
    gr_cntr_if #(.WIDTH(6)) if6 ();

    gr_cntr #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .gr_if (if4)
    );

    gr_cntr #(.WIDTH(6)) u_dut6 (
        .clk   (clk),
        .rst   (rst),
        .gr_if (if6)
    );

    always #5 clk = ~clk;

    // Reference binary counts, advanced on the same edges as the DUTs.
    logic [3:0] ref_bin4 = '0;
    logic [5:0] ref_bin6 = '0;

    always @(posedge clk) begin
        if (rst) begin
            ref_bin4 <= '0;
            ref_bin6 <= '0;
        end else begin
            ref_bin4 <= ref_bin4 + 4'd1;
            ref_bin6 <= ref_bin6 + 6'd1;
        end
    end

    // Hand-written WIDTH=4 Gray sequence.
    logic [3:0] seq4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                              4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110,
                              4'b1010, 4'b1011, 4'b1001, 4'b1000};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    logic [3:0] prev4;
    logic [5:0] prev6;
    logic [5:0] exp6;

    initial begin
        // Power-up: no reset yet, output must already be zero.
        #1;
        check_eq("pwrup_t0_w4", {28'd0, if4.gr}, 32'd0);
        check_eq("pwrup_t0_w6", {26'd0, if6.gr}, 32'd0);
        tick();
        check_eq("pwrup_edge1_w4", {28'd0, if4.gr}, 32'd1);
        check_eq("pwrup_edge1_w6", {26'd0, if6.gr}, 32'd1);

        // Reset held for two edges.
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("rst_hold_%0d", i), {28'd0, if4.gr}, 32'd0);
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check_eq($sformatf("post_rst_%0d", i), {28'd0, if4.gr}, {28'd0, seq4[i]});
        end

        // Full cycle from reset, including wrap and one step past it.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev4 = if4.gr;
        for (int i = 1; i <= 17; i++) begin
            tick();
            check_eq($sformatf("cycle_%0d", i), {28'd0, if4.gr}, {28'd0, seq4[i % 16]});
            check_eq($sformatf("cycle_hd_%0d", i), $countones(if4.gr ^ prev4), 32'd1);
            check_eq($sformatf("cycle_inv_%0d", i), {28'd0, if4.gr},
                     {28'd0, ref_bin4 ^ (ref_bin4 >> 1)});
            prev4 = if4.gr;
        end

        // Mid-run reset at 0110.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_eq("mid_pre", {28'd0, if4.gr}, 32'b0110);
        rst = 1'b1;
        tick();
        check_eq("mid_rst", {28'd0, if4.gr}, 32'd0);
        rst = 1'b0;
        tick();
        check_eq("mid_restart", {28'd0, if4.gr}, 32'd1);

        // Wide instance over more than a full period, crossing wrap.
        rst = 1'b1;
        tick();
        check_eq("w6_rst", {26'd0, if6.gr}, 32'd0);
        rst = 1'b0;
        prev6 = if6.gr;
        for (int i = 1; i <= 70; i++) begin
            tick();
            exp6 = 6'(i % 64);
            exp6 = exp6 ^ (exp6 >> 1);
            check_eq($sformatf("w6_val_%0d", i), {26'd0, if6.gr}, {26'd0, exp6});
            check_eq($sformatf("w6_hd_%0d", i), $countones(if6.gr ^ prev6), 32'd1);
            check_eq($sformatf("w6_inv_%0d", i), {26'd0, if6.gr},
                     {26'd0, ref_bin6 ^ (ref_bin6 >> 1)});
            prev6 = if6.gr;
        end
        check_eq("w6_wrap_top", {26'd0, u_dut6.gr_if.gr}, {26'd0, 6'b000101});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
